// File: rtl/riscv_dmem_wait.sv
// Data memory with a request/done handshake and independent read/write latencies.
// One access outstanding; misaligned or out-of-range accesses complete with err instead of aliasing.
module riscv_dmem_wait #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH_BIT  = 10,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_dmem_req,
  input  logic            i_dmem_wr_en,
  input  logic [XLEN-1:0] i_dmem_addr,
  input  logic [3:0]      i_dmem_byte_sel,
  input  logic [XLEN-1:0] i_dmem_wr_data,
  output logic            o_dmem_ready,
  output logic            o_dmem_done,
  output logic            o_dmem_rd_valid,
  output logic [XLEN-1:0] o_dmem_rd_data,
  output logic            o_dmem_err
);

  localparam int unsigned DEPTH   = 1 << DEPTH_BIT;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned N_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DEPTH_BIT-1:0]   idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic [N_LANES-1:0]     bsel_q, bsel_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_out_q, err_out_d;
  logic [XLEN-1:0]        rd_data_q, rd_data_d;
  logic                   commit_c;
  logic                   addr_err_c;
  logic                   mem_we_c;

  logic [XLEN-1:0] mem [DEPTH];

  // Misaligned word address or any bit above the array index range.
  assign addr_err_c = (i_dmem_addr[1:0] != 2'b00) ||
                      ((i_dmem_addr >> (DEPTH_BIT + 2)) != '0);

  // Next-state, capture and commit; commit_c marks the edge that enters RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    bsel_d    = bsel_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    commit_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_dmem_req) begin
          idx_d   = i_dmem_addr[DEPTH_BIT+1:2];
          wr_d    = i_dmem_wr_en;
          bsel_d  = i_dmem_byte_sel;
          wdata_d = i_dmem_wr_data;
          err_d   = addr_err_c;
          cnt_d   = i_dmem_wr_en ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
          if (cnt_d == '0) begin
            state_d  = ST_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d  = ST_RESP;
          commit_c = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (commit_c && !wr_d && !err_d) begin
      rd_data_d = mem[idx_d];
    end

    ready_d    = (state_d == ST_IDLE);
    done_d     = (state_d == ST_RESP);
    err_out_d  = done_d && err_d;
    rd_valid_d = done_d && !wr_d && !err_d;
  end

  // Reset gate keeps a request seen during reset from writing the array.
  assign mem_we_c = commit_c && wr_d && !err_d && i_rstn;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      bsel_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      err_out_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      bsel_q     <= bsel_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      err_out_q  <= err_out_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array has no reset so contents survive i_rstn.
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (bsel_d[i]) begin
          mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
        end
      end
    end
  end

  assign o_dmem_ready    = ready_q;
  assign o_dmem_done     = done_q;
  assign o_dmem_rd_valid = rd_valid_q;
  assign o_dmem_err      = err_out_q;
  assign o_dmem_rd_data  = rd_data_q;

endmodule
